// File: rtl/ram72x4_pkg.sv
// Shared constants and RAM command encoding for the 72x4 RAM FIFO sequencer.
package ram72x4_pkg;

  localparam int DW       = 72;      // data width, equal to the RAM word
  localparam int AW       = 2;       // RAM address width
  localparam int DEPTH    = 2 ** AW; // RAM words used as main storage
  localparam int OB_DEPTH = 2;       // output buffer entries (fixed)
  localparam int LVL_W    = 3;       // width of the occupancy output (0..6)
  localparam int RC_W     = AW + 1;  // width of the RAM occupancy counter (0..4)
  localparam int OBC_W    = 2;       // width of the output buffer count (0..2)

  // What the sequencer asks of the RAM in a given cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ram_cmd_e;

  // Active-low enable: asserted for any access.
  function automatic logic cmd_en_n(input ram_cmd_e cmd);
    return (cmd == IDLE);
  endfunction

  // Active-low write strobe: asserted only for writes.
  function automatic logic cmd_wr_n(input ram_cmd_e cmd);
    return (cmd != WRITE);
  endfunction

endpackage

// File: rtl/ram72x4_outbuf.sv
// Two-entry shift buffer holding the head of the queue. Entry 0 is always
// the head; a pop shifts entry 1 down, and a push lands in the first free
// slot after that shift, so pop and push may share a cycle even when full.
module ram72x4_outbuf
  import ram72x4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [DW-1:0]    i_push_data,
  input  logic             i_pop,
  output logic [OBC_W-1:0] o_count,
  output logic [DW-1:0]    o_head
);

  logic [OBC_W-1:0] r_count;
  logic [OBC_W-1:0] w_idx;
  logic [DW-1:0]    w_ent [OB_DEPTH];

  // Slot that receives a push, measured after any simultaneous pop.
  assign w_idx = r_count - OBC_W'(i_pop);

  genvar gi;
  generate
    for (gi = 0; gi < OB_DEPTH; gi++) begin : g_ent
      logic [DW-1:0] r_ent;
      logic [DW-1:0] w_shift;

      if (gi < OB_DEPTH - 1) begin : g_mid
        assign w_shift = w_ent[gi+1];
      end else begin : g_last
        assign w_shift = r_ent;
      end

      // Entry update: a push into this slot wins, otherwise shift on pop.
      always_ff @(posedge clk) begin
        if (i_push && (w_idx == OBC_W'(gi))) begin
          r_ent <= i_push_data;
        end else if (i_pop) begin
          r_ent <= w_shift;
        end
      end

      assign w_ent[gi] = r_ent;
    end
  endgenerate

  // Occupancy count; data registers need no reset because the head is masked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + OBC_W'(i_push) - OBC_W'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? w_ent[0] : '0;

endmodule

// File: rtl/ram72x4_fifo_ctrl.sv
// FIFO sequencer in front of the 72x4 single-port RAM. Four RAM words form
// the main store; a two-entry output buffer hides the RAM read latency.
// Reads take priority over writes on the single RAM port.
// Optional macro RAMCTL_BYPASS_EN: when the RAM path is empty, a push goes
// straight into the output buffer so the word appears on the next cycle.
module ram72x4_fifo_ctrl
  import ram72x4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [LVL_W-1:0] level,
  output logic             ram_en_n,
  output logic             ram_wr_n,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_rdata
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [RC_W-1:0]  r_ram_count;
  logic             r_rd_pend;

  logic [OBC_W-1:0] w_ob_count;
  logic [DW-1:0]    w_ob_head;
  logic             w_pop;
  logic [2:0]       w_room;
  logic             w_rd_issue;
  logic             w_ram_ok;
  logic             w_push;
  logic             w_ram_push;
  logic             w_ob_push;
  logic [DW-1:0]    w_ob_data;
  ram_cmd_e         w_cmd;

  assign out_valid = !rst && (w_ob_count != '0);
  assign out_data  = w_ob_head;
  assign w_pop     = out_valid && out_ready;

  // Slots already spoken for in the output buffer once this cycle's pop leaves.
  assign w_room     = 3'(w_ob_count) + 3'(r_rd_pend) - 3'(w_pop);
  assign w_rd_issue = !rst && (r_ram_count != '0) && (w_room < 3'd2);
  assign w_ram_ok   = !w_rd_issue && (r_ram_count < RC_W'(DEPTH));

`ifdef RAMCTL_BYPASS_EN
  logic w_byp_ok;
  logic w_byp_push;

  // Nothing older is in the RAM path and the buffer has space after the pop.
  assign w_byp_ok   = (r_ram_count == '0) && !r_rd_pend &&
                      ((w_ob_count - OBC_W'(w_pop)) < OBC_W'(2));
  assign in_ready   = !rst && (w_ram_ok || w_byp_ok);
  assign w_push     = in_valid && in_ready;
  assign w_byp_push = w_push && w_byp_ok;
  assign w_ram_push = w_push && !w_byp_ok;
  // Capture and bypass are exclusive: bypass needs no read in flight.
  assign w_ob_push  = r_rd_pend || w_byp_push;
  assign w_ob_data  = r_rd_pend ? ram_rdata : in_data;
`else
  assign in_ready   = !rst && w_ram_ok;
  assign w_push     = in_valid && in_ready;
  assign w_ram_push = w_push;
  assign w_ob_push  = r_rd_pend;
  assign w_ob_data  = ram_rdata;
`endif

  ram72x4_outbuf u_outbuf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_ob_push),
    .i_push_data (w_ob_data),
    .i_pop       (w_pop),
    .o_count     (w_ob_count),
    .o_head      (w_ob_head)
  );

  // Choose this cycle's RAM command; a read always wins the port.
  always_comb begin
    w_cmd = IDLE;
    if (w_rd_issue) begin
      w_cmd = READ;
    end else if (w_ram_push) begin
      w_cmd = WRITE;
    end
  end

  assign ram_en_n = cmd_en_n(w_cmd);
  assign ram_wr_n = cmd_wr_n(w_cmd);

  // Address and write data are driven only during an access, zero otherwise.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    case (w_cmd)
      READ:    ram_addr = r_rd_ptr;
      WRITE: begin
        ram_addr  = r_wr_ptr;
        ram_wdata = in_data;
      end
      default: ;
    endcase
  end

  // Pointers, RAM occupancy and the read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_ram_push) begin
        r_wr_ptr    <= r_wr_ptr + AW'(1);
        r_ram_count <= r_ram_count + RC_W'(1);
      end else if (w_rd_issue) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_ram_count <= r_ram_count - RC_W'(1);
      end
    end
  end

  assign level = rst ? '0 :
                 (LVL_W'(r_ram_count) + LVL_W'(r_rd_pend) + LVL_W'(w_ob_count));

endmodule

// File: tb/tb_ram72x4_fifo_ctrl.sv
// Directed bench for ram72x4_fifo_ctrl with a behavioural model of the
// 72x4 RAM and a queue-based scoreboard of expected output words.
module tb_ram72x4_fifo_ctrl;

  localparam int DW = 72;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    level;
  logic          ram_en_n;
  logic          ram_wr_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [4];

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] exp_q [$];
  int            model_cnt = 0;
  logic [AW-1:0] model_wptr = '0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  logic          o_en_n, o_wr_n, o_valid, o_in_ready;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [2:0]    o_level;
  logic          last_acc;

  ram72x4_fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ram_en_n  (ram_en_n),
    .ram_wr_n  (ram_wr_n),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // 72x4 single-port RAM with registered read data.
  always @(posedge clk) begin
    if (!ram_en_n) begin
      if (!ram_wr_n) mem[ram_addr] <= ram_wdata;
      else           ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check settled outputs, advance the model.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic acc_push, acc_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    o_en_n = ram_en_n; o_wr_n = ram_wr_n; o_addr = ram_addr;
    o_valid = out_valid; o_data = out_data; o_level = level; o_in_ready = in_ready;
    acc_push = in_valid && in_ready;
    acc_pop  = out_valid && out_ready;
    last_acc = acc_push;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_en_n", ram_en_n, 1);
      chk("rst_wr_n", ram_wr_n, 1);
    end else begin
      chk("level", level, model_cnt);
      if (model_cnt == 6) chk("full_in_ready", in_ready, 0);
      if (!out_valid) chk("empty_data", out_data, 0);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_data);
      end
      if (acc_pop) begin
        if (exp_q.size() == 0) chk("pop_unexpected", out_valid, 0);
        else chk("pop_data", out_data, exp_q.pop_front());
      end
      if (!ram_en_n && ram_wr_n) chk("read_blocks_push", in_ready, 0);
`ifndef RAMCTL_BYPASS_EN
      if (acc_push) begin
        chk("push_wr_n", ram_wr_n, 0);
        chk("push_addr", ram_addr, model_wptr);
        chk("push_wdata", ram_wdata, d);
        model_wptr = model_wptr + 1'b1;
      end
`endif
      if (acc_push) begin
        exp_q.push_back(d);
        model_cnt++;
      end
      if (acc_pop) model_cnt--;
    end
    stall_prev = !rst && out_valid && !out_ready;
    stall_data = out_data;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_cnt  = 0;
      model_wptr = '0;
      stall_prev = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1'b0, '0, 1'b1);
    chk("drain_left", DW'(exp_q.size()), 0);
  endtask

  initial begin
    logic [DW-1:0] w;
    int            k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset from power-up.
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);
    chk("init_in_ready", o_in_ready, 1);
    chk("init_en_n", o_en_n, 1);

    // Single word latency.
    w = 72'hA5A5_A5A5_A5A5_A5A5_01;
    cyc(1'b1, w, 1'b1);
    chk("single_acc", last_acc, 1);
`ifdef RAMCTL_BYPASS_EN
    chk("single_byp_en_n", o_en_n, 1);
    cyc(1'b0, '0, 1'b1);
    chk("single_t1_valid", o_valid, 1);
    chk("single_t1_data", o_data, w);
`else
    chk("single_wr_en_n", o_en_n, 0);
    chk("single_wr_addr", o_addr, 0);
    cyc(1'b0, '0, 1'b1);
    chk("single_rd_en_n", o_en_n, 0);
    chk("single_rd_wr_n", o_wr_n, 1);
    chk("single_rd_addr", o_addr, 0);
    cyc(1'b0, '0, 1'b1);
    chk("single_t2_valid", o_valid, 0);
    cyc(1'b0, '0, 1'b1);
    chk("single_t3_valid", o_valid, 1);
    chk("single_t3_data", o_data, w);
`endif
    drain();

    // Fill with backpressure: offer words 1..8, only 6 fit.
    k = 1;
    for (int i = 0; i < 16; i++) begin
      cyc(k <= 8, (k <= 8) ? DW'(k) : '0, 1'b0);
      if (last_acc) k++;
    end
    cyc(1'b0, '0, 1'b0);
    chk("fill_level", o_level, 6);
    chk("fill_in_ready", o_in_ready, 0);
    drain();

    // Continuous push with free-running pop: reads must block pushes.
    for (int i = 0; i < 12; i++) cyc(1'b1, DW'(32'h100 + i), 1'b1);
    drain();

    // Random words with out_ready toggling 1010...
    k = 0;
    for (int i = 0; i < 200 && k < 20; i++) begin
      w = {8'($urandom), $urandom, $urandom};
      cyc(1'b1, w, (i % 2) == 0);
      if (last_acc) k++;
    end
    chk("bp_all_pushed", DW'(k), 20);
    drain();

    // Full plus simultaneous pop and push.
    for (int i = 0; i < 30 && model_cnt < 6; i++) cyc(1'b1, DW'(32'h200 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("full_level", o_level, 6);
    cyc(1'b1, DW'(32'h3AA), 1'b1);
    chk("full_pop_push_rej", o_in_ready, 0);
    cyc(1'b1, DW'(32'h3AA), 1'b0);
    chk("full_next_level", o_level, 5);
    chk("full_next_acc", o_in_ready, 1);
    cyc(1'b0, '0, 1'b0);
    chk("full_refill_level", o_level, 6);
    drain();

    // Reset mid-stream at level 5.
    for (int i = 0; i < 30 && model_cnt < 5; i++) cyc(1'b1, DW'(32'h400 + i), 1'b0);
    chk("pre_rst_level", DW'(model_cnt), 5);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_level", o_level, 0);
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_en_n", o_en_n, 1);
    cyc(1'b1, DW'(72'h55), 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram72x4_fifo_ctrl.md
Name: ram72x4_fifo_ctrl

Overview:
- FIFO sequencer sitting directly upstream/downstream of the 72x4 single-port RAM macro: drives its active-low en/wr, 2-bit address and 72-bit write data, and consumes its registered read data.
- Presents a valid/ready push port and a valid/ready pop port, giving an in-order 72-bit queue.
- Uses the 4 RAM words as main storage plus a 2-entry output buffer that hides the RAM's 1-cycle read latency.

Parameters:
- DW, 72, data width (must match RAM word).
- AW, 2, RAM address width; DEPTH = 2**AW = 4 words.
- OB_DEPTH, 2, output buffer entries (fixed; other values unsupported).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid&&in_ready.
- in_data  in  DW  push word.
- out_valid  out  1  head word available.
- out_ready  in  1  pop when out_valid&&out_ready.
- out_data  out  DW  head word.
- level  out  3  words held: ram_count + rd_pend + ob_count (0..6).
- ram_en_n  out  1  to RAM en, active low.
- ram_wr_n  out  1  to RAM wr, active low.
- ram_addr  out  AW  to RAM address.
- ram_wdata  out  DW  to RAM data_in.
- ram_rdata  in  DW  from RAM data_out; valid the cycle after a read is issued.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- State: wr_ptr, rd_ptr (AW bits, wrap 3->0); ram_count (0..4); rd_pend (1 bit); ob_count (0..2); ob[0..1] registers with out_data = ob head.
- Reset (rst=1 at an edge): pointers, ram_count, rd_pend, ob_count cleared; RAM contents untouched.
  - Outputs during and after reset: out_valid=0, level=0, ram_en_n=1, ram_wr_n=1.
  - in_ready is forced 0 while rst=1.
  - Reset mid-operation discards all words, including an in-flight read.
- pop = out_valid && out_ready.
- Read issue: rd_issue = (ram_count!=0) && (ob_count + rd_pend - pop < 2).
  - Drives ram_en_n=0, ram_wr_n=1, ram_addr=rd_ptr; rd_ptr++, ram_count--, rd_pend<=1.
  - Otherwise rd_pend<=0.
- Capture: when rd_pend=1, ram_rdata is written into the ob tail that cycle. A simultaneous pop shifts ob first, so no overflow.
- Single port: read has priority. in_ready = !rst && !rd_issue && (ram_count<4).
  - Push drives ram_en_n=0, ram_wr_n=0, ram_addr=wr_ptr, ram_wdata=in_data combinationally; wr_ptr++, ram_count++.
- Idle (no issue, no push): ram_en_n=1, ram_wr_n=1, ram_addr=0, ram_wdata=0.
- Simultaneous push and rd_issue cannot occur; simultaneous push and pop are allowed.
- Latency (feature off): push in cycle t -> read issued t+1 -> rdata t+2 -> out_valid at t+3. Sustained throughput is 1 word/cycle on the pop side only when pushes stall.
- Full: level=6 → in_ready=0. Empty: out_valid=0.
- Ordering: strict FIFO.
- out_data holds when out_valid=1 && out_ready=0; out_data is 0 when empty.

Optional Feature:
- RAMCTL_BYPASS_EN defined: push bypasses the RAM when ram_count==0 && rd_pend==0 && (ob_count - pop) < 2.
  - The word is written straight into ob, with no RAM access (ram_en_n=1).
  - out_valid is asserted at t+1.
  - in_ready additionally allows bypass pushes; otherwise identical.
- Undefined: all words pass through the RAM; latency is 3.

Decomposition:
- Package ram72x4_pkg holds: DW, AW, DEPTH, OB_DEPTH constants; LVL_W=3; the ram_cmd enum {IDLE, WRITE, READ} used to decode the (en_n, wr_n) pair.
- Sub-module ram72x4_outbuf: 2-entry shift/skid buffer with push (capture or bypass), pop, count and head outputs.

Test Plan:
- Reset: rst=1 for 2 cycles mid-stream with level=5 -> next cycle level=0, out_valid=0, ram_en_n=1; RAM contents not cleared.
- Single word: push 72'hA5...01 at t, out_ready=1 -> RAM write to addr 0 at t, read addr 0 at t+1, out_valid/out_data=72'hA5...01 at t+3 (t+1 with RAMCTL_BYPASS_EN).
- Fill: out_ready=0, push 8 words 1..8 -> words 1..6 accepted, in_ready=0 at level=6; then pop 6 words -> output order 1..6 with pointer wrap 3->0 exercised.
- Priority: ram_count=2, ob_count=0, in_valid=1 continuously -> read cycles show in_ready=0 and ram_wr_n=1; no push lost or duplicated.
- Backpressure: out_ready toggled 1010..., 20 random words -> scoreboard order matches; out_data stable while stalled; ob never exceeds 2.
- Full plus simultaneous: at level=6, pop and push in the same cycle -> push rejected that cycle (ram_count=4); accepted the next cycle; level goes 6->5->6.
